axi_read_responder: RTL and testbench
=====================================

// Module: axi_read_responder
// PURPOSE
//  AXI4 read-side slave front end of the cache: the AR/R counterpart of the AW/W write merger.
//  - Accepts one AR burst at a time.
//  - Walks the burst one beat at a time, issuing a single-word read request to the cache core per beat.
//  - Returns each word on the R channel with RID/RRESP/RLAST.
//  - Sits between the AXI interconnect and the cache data-array read port.
// PARAMETERS
//  AXI_ADDR_WIDTH  32  byte address width
//  AXI_DATA_WIDTH  64  R data width; max ARSIZE = log2(AXI_DATA_WIDTH/8)
//  AXI_ID_WIDTH    4   ARID/RID width
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous, active-high reset
//  arvalid        in   1       AR valid
//  arready        out  1       AR ready
//  araddr         in   ADDR    burst start address
//  arid           in   ID      transaction ID
//  arburst        in   2       00 FIXED, 01 INCR, 10 WRAP (11 reserved)
//  arsize         in   3       bytes/beat = 1<<arsize
//  arlen          in   8       beats-1
//  rvalid         out  1       R valid
//  rready         in   1       R ready
//  rdata          out  DATA    read data
//  rresp          out  2       00 OKAY, 10 SLVERR
//  rid            out  ID      echoed ARID
//  rlast          out  1       final beat
//  mem_req_valid  out  1       cache read request
//  mem_req_ready  in   1       cache accepts request
//  mem_req_addr   out  ADDR    beat address
//  mem_rsp_valid  in   1       cache data returned (no backpressure; 1-cycle pulse)
//  mem_rsp_data   in   DATA    returned word
//  mem_rsp_err    in   1       cache/backing error -> SLVERR on this beat
// BEHAVIOUR
//  - Reset: all outputs 0 (arready=0 during reset), FSM=IDLE, beat counter=0.
//  - FSM states and transitions:
//    - IDLE: arready=1. On arvalid&arready, capture id/addr/burst/size/len; beat_cnt=0; go REQ.
//    - REQ: mem_req_valid=1, mem_req_addr=cur_addr. On mem_req_ready, go WAIT.
//    - WAIT: on mem_rsp_valid, register data/err into the R output stage; go RESP.
//    - RESP: rvalid=1; rlast=(beat_cnt==len). On rvalid&rready:
//      - if rlast, go IDLE;
//      - else beat_cnt++, cur_addr=next_addr, go REQ.
//  - Latency: AR handshake at cycle N -> mem_req_valid at N+1. mem_rsp_valid at M -> rvalid at M+1.
//    R handshake at K (not last) -> next mem_req_valid at K+1.
//  - Single outstanding burst and single outstanding beat; arready stays 0 from AR accept until the last R handshake.
//  - Handshake stability: R outputs (rvalid/rdata/rresp/rid/rlast) and mem_req_valid/mem_req_addr are stable while stalled by rready=0 or mem_req_ready=0.
//  - mem_rsp_valid outside WAIT is ignored (bench asserts it never occurs).
//  - Address generation (bytes = 1<<size):
//    - FIXED: every beat uses the start address.
//    - INCR: next = (cur & ~(bytes-1)) + bytes, computed modulo 2^ADDR. The first beat may be unaligned; later beats are aligned.
//    - WRAP: span = bytes*(len+1); lo = start & ~(span-1); next = cur+bytes, and if next == lo+span then next = lo.
//  - Reserved arburst=11 is treated as INCR. rresp=10 iff mem_rsp_err.
//  - Reset mid-burst: burst dropped silently, no further R beats; outstanding cache response discarded.
// CONFIGURATION
//  - Macro AXI_RD_LEGALITY_CHECK_EN. When defined, on AR accept the burst is flagged illegal if any of:
//    - arsize > log2(DATA/8);
//    - WRAP with arlen not in {1,3,7,15};
//    - WRAP with unaligned araddr;
//    - INCR crossing a 4 KB boundary;
//    - arburst=11.
//  - Illegal bursts skip REQ/WAIT: all len+1 beats go out via RESP with rresp=10, rdata=0, correct rlast, and no mem_req issued.
//  - Undefined: no checks; every burst is serviced as described above.
// STRUCTURE
//  - Package axi_cache_pkg holds:
//    - burst_t enum (FIXED/INCR/WRAP/RSVD);
//    - RESP_OKAY/RESP_SLVERR constants;
//    - rd_state_t enum (IDLE/REQ/WAIT/RESP);
//    - ar_beat_t struct (id, addr, burst, size, len).
//  - One sub-module: axi_burst_addr_gen (combinational next_addr from cur/start/burst/size/len), shared later with the write path.
// TESTING
//  - INCR: araddr=0x100, arsize=3, arlen=3, arid=5 -> mem_req_addr 0x100,0x108,0x110,0x118; 4 R beats rid=5, rlast only on 4th, rresp=00.
//  - WRAP: araddr=0x118, arsize=3, arlen=3 -> addresses 0x118,0x100,0x108,0x110.
//  - FIXED + unaligned INCR: FIXED 0x40, arlen=2 -> three reqs at 0x40. INCR 0x103, arsize=2, arlen=1 -> 0x103, 0x104.
//  - Backpressure: rready=0 for 5 cycles, mem_req_ready delayed 3 cycles -> rdata/rlast stable, no dropped or duplicate beats, arready=0 until final R handshake.
//  - Error/reset: mem_rsp_err on beat 2 of 4 -> only that beat rresp=10. rst pulsed during WAIT -> rvalid=0, arready=1 the cycle after reset release.
//  - With AXI_RD_LEGALITY_CHECK_EN: WRAP arlen=2 -> 3 beats rresp=10, rdata=0, mem_req_valid never asserted.

Source files
------------

// File: rtl/axi_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_cache_pkg
// Purpose  : Shared types and constants for the AXI front end of the cache
//            (read responder now, write merger later).
// Contents : burst_t    - AXI burst encoding (FIXED/INCR/WRAP/RSVD)
//            RESP_*     - R/B response codes
//            rd_state_t - read responder FSM states
//            ar_beat_t  - captured AR burst descriptor
// Revision : 1.0 - initial release
// ============================================================================
package axi_cache_pkg;

  // Widths of the captured AR descriptor; the responder top checks at
  // elaboration that its own parameters agree with these.
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W   = 4;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } rd_state_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    burst_t                burst;
    logic [2:0]            size;
    logic [7:0]            len;
  } ar_beat_t;

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_addr_gen
// Purpose  : Combinational AXI4 next-beat address generator, shared by the
//            read and write paths.
// Ports    : i_cur_addr   - address of the beat just completed
//            i_start_addr - burst start address (FIXED value, WRAP base)
//            i_burst      - burst type (RSVD behaves as INCR)
//            i_size       - log2 bytes per beat
//            i_len        - beats-1
//            o_next_addr  - address of the following beat
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
  import axi_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_cur_addr,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  burst_t                i_burst,
  input  logic [2:0]            i_size,
  input  logic [7:0]            i_len,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);

  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_span;
  logic [ADDR_WIDTH-1:0] w_wrap_lo;
  logic [ADDR_WIDTH-1:0] w_incr;

  // bytes and span are powers of two (for legal WRAP lengths), so
  // multiplication reduces to shifts.
  assign w_bytes   = ADDR_WIDTH'(1) << i_size;
  assign w_span    = ADDR_WIDTH'({1'b0, i_len} + 9'd1) << i_size;
  assign w_wrap_lo = i_start_addr & ~(w_span - ADDR_WIDTH'(1));
  assign w_incr    = i_cur_addr + w_bytes;

  always_comb begin
    o_next_addr = i_start_addr;
    case (i_burst)
      FIXED: o_next_addr = i_start_addr;
      WRAP:  o_next_addr = (w_incr == w_wrap_lo + w_span) ? w_wrap_lo : w_incr;
      // INCR and reserved: align the current beat down, then step one beat.
      default: o_next_addr = (i_cur_addr & ~(w_bytes - ADDR_WIDTH'(1))) + w_bytes;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_responder
// Purpose  : AXI4 read-side slave front end of the cache. Accepts one AR
//            burst at a time, issues one single-word cache read per beat and
//            returns each word on R with RID/RRESP/RLAST.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            ar*                - AXI read address channel (slave side)
//            r*                 - AXI read data channel (slave side)
//            mem_req_*          - cache read request (valid/ready, address)
//            mem_rsp_*          - cache read response (1-cycle pulse, no ready)
// Config   : AXI_RD_LEGALITY_CHECK_EN - when defined, illegal AR bursts are
//            answered with len+1 SLVERR beats (rdata=0) without touching the
//            cache. Undefined: every burst is serviced.
// Revision : 1.0 - initial release
// ============================================================================
module axi_read_responder
  import axi_cache_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr,
  input  logic [AXI_ID_WIDTH-1:0]   arid,
  input  logic [1:0]                arburst,
  input  logic [2:0]                arsize,
  input  logic [7:0]                arlen,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [AXI_DATA_WIDTH-1:0] rdata,
  output logic [1:0]                rresp,
  output logic [AXI_ID_WIDTH-1:0]   rid,
  output logic                      rlast,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [AXI_ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                      mem_rsp_valid,
  input  logic [AXI_DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                      mem_rsp_err
);

  if (AXI_ADDR_WIDTH != AXI_ADDR_W || AXI_ID_WIDTH != AXI_ID_W) begin : g_width_check
    $error("axi_read_responder: ADDR/ID widths must match axi_cache_pkg");
  end

  rd_state_t                 state_q, state_d;
  ar_beat_t                  beat_q, beat_d;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]                beat_cnt_q, beat_cnt_d;
  logic                      illegal_q, illegal_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic                      rlast_q, rlast_d;
  logic                      mem_req_valid_q, mem_req_valid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;
  logic                      ar_illegal;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (AXI_ADDR_WIDTH)
  ) u_addr_gen (
    .i_cur_addr   (cur_addr_q),
    .i_start_addr (beat_q.addr),
    .i_burst      (beat_q.burst),
    .i_size       (beat_q.size),
    .i_len        (beat_q.len),
    .o_next_addr  (next_addr)
  );

`ifdef AXI_RD_LEGALITY_CHECK_EN
  localparam int MAX_SIZE = $clog2(AXI_DATA_WIDTH / 8);

  logic [11:0] ar_mask;
  logic [11:0] ar_off;
  logic [19:0] ar_end;
  logic        size_bad, wrap_len_bad, wrap_unaligned, incr_4k_cross;

  // Only the low 12 bits matter for the 4 KB check: the burst crosses a page
  // iff its aligned in-page offset plus total length exceeds 4096.
  assign ar_mask        = (12'd1 << arsize) - 12'd1;
  assign ar_off         = araddr[11:0] & ~ar_mask;
  assign ar_end         = {8'd0, ar_off} + (20'({1'b0, arlen} + 9'd1) << arsize);
  assign size_bad       = arsize > 3'(MAX_SIZE);
  assign wrap_len_bad   = (arburst == WRAP) && !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15});
  assign wrap_unaligned = (arburst == WRAP) && ((araddr[11:0] & ar_mask) != 12'd0);
  assign incr_4k_cross  = (arburst == INCR) && (ar_end > 20'd4096);
  assign ar_illegal     = size_bad || wrap_len_bad || wrap_unaligned || incr_4k_cross ||
                          (arburst == RSVD);
`else
  assign ar_illegal = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    cur_addr_d = cur_addr_q;
    beat_cnt_d = beat_cnt_q;
    illegal_d  = illegal_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    case (state_q)
      IDLE: begin
        if (arvalid && arready_q) begin
          beat_d     = '{id: arid, addr: araddr, burst: burst_t'(arburst),
                         size: arsize, len: arlen};
          cur_addr_d = araddr;
          beat_cnt_d = 8'd0;
          illegal_d  = ar_illegal;
          if (ar_illegal) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          rdata_d = mem_rsp_data;
          rresp_d = mem_rsp_err ? RESP_SLVERR : RESP_OKAY;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rready) begin
          if (rlast_q) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            cur_addr_d = next_addr;
            // Illegal bursts keep streaming error beats; rdata/rresp hold 0/SLVERR.
            state_d    = illegal_q ? RESP : REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered versions of what the next state implies.
    arready_d       = (state_d == IDLE);
    mem_req_valid_d = (state_d == REQ);
    rvalid_d        = (state_d == RESP);
    rlast_d         = (state_d == RESP) && (beat_cnt_d == beat_d.len);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      beat_q          <= '0;
      cur_addr_q      <= '0;
      beat_cnt_q      <= 8'd0;
      illegal_q       <= 1'b0;
      arready_q       <= 1'b0;
      rvalid_q        <= 1'b0;
      rlast_q         <= 1'b0;
      mem_req_valid_q <= 1'b0;
      rdata_q         <= '0;
      rresp_q         <= RESP_OKAY;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      cur_addr_q      <= cur_addr_d;
      beat_cnt_q      <= beat_cnt_d;
      illegal_q       <= illegal_d;
      arready_q       <= arready_d;
      rvalid_q        <= rvalid_d;
      rlast_q         <= rlast_d;
      mem_req_valid_q <= mem_req_valid_d;
      rdata_q         <= rdata_d;
      rresp_q         <= rresp_d;
    end
  end

  assign arready       = arready_q;
  assign rvalid        = rvalid_q;
  assign rdata         = rdata_q;
  assign rresp         = rresp_q;
  assign rid           = beat_q.id;
  assign rlast         = rlast_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = cur_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_read_responder
// Purpose  : Self-checking bench for axi_read_responder. Directed bursts plus
//            randomized bursts, each checked beat by beat against a reference
//            that derives beat addresses arithmetically from the burst rules.
//            Honours AXI_RD_LEGALITY_CHECK_EN in its reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_read_responder;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic [IW-1:0] arid;
  logic [1:0]    arburst;
  logic [2:0]    arsize;
  logic [7:0]    arlen;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [IW-1:0] rid;
  logic          rlast;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic          mem_rsp_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  axi_read_responder #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .AXI_ID_WIDTH   (IW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .arvalid       (arvalid),
    .arready       (arready),
    .araddr        (araddr),
    .arid          (arid),
    .arburst       (arburst),
    .arsize        (arsize),
    .arlen         (arlen),
    .rvalid        (rvalid),
    .rready        (rready),
    .rdata         (rdata),
    .rresp         (rresp),
    .rid           (rid),
    .rlast         (rlast),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Address of beat 'beat' of a burst, straight from the burst definitions.
  function automatic logic [AW-1:0] ref_addr(input logic [AW-1:0] start, input logic [1:0] burst,
                                             input logic [2:0] size, input logic [7:0] len,
                                             input int beat);
    longint unsigned bytes = 64'd1 << size;
    longint unsigned span  = bytes * (longint'(len) + 1);
    longint unsigned s     = start;
    longint unsigned lo;
    if (burst == 2'b00) return start;
    if (burst == 2'b10) begin
      lo = (s / span) * span;
      return AW'(lo + ((s - lo + longint'(beat) * bytes) % span));
    end
    if (beat == 0) return start;
    return AW'((s / bytes) * bytes + longint'(beat) * bytes);
  endfunction

  function automatic bit ref_illegal(input logic [AW-1:0] start, input logic [1:0] burst,
                                     input logic [2:0] size, input logic [7:0] len);
`ifdef AXI_RD_LEGALITY_CHECK_EN
    longint unsigned bytes = 64'd1 << size;
    longint unsigned s     = start;
    if (size > 3'd3) return 1'b1;
    if (burst == 2'b11) return 1'b1;
    if (burst == 2'b10)
      return !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) || (s % bytes != 0);
    if (burst == 2'b01)
      return (((s / bytes) * bytes) % 4096) + bytes * (longint'(len) + 1) > 4096;
    return 1'b0;
`else
    return (start == '0) && (burst == 2'b00) && (size == 3'd0) && (len == 8'd0) && 1'b0;
`endif
  endfunction

  task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] start,
                           input logic [1:0] burst, input logic [2:0] size, input logic [7:0] len,
                           input int req_stall, input int rsp_delay, input int r_stall,
                           input int err_beat);
    bit            ill;
    int            waited;
    logic [DW-1:0] d;
    logic          e;
    logic [AW-1:0] a;
    ill     = ref_illegal(start, burst, size, len);
    arvalid = 1'b1;
    arid    = id;
    araddr  = start;
    arburst = burst;
    arsize  = size;
    arlen   = len;
    waited  = 0;
    while (!arready && waited < 50) begin
      tick();
      waited++;
    end
    check("ar_ready_timeout", arready, 1);
    tick();
    arvalid = 1'b0;
    check("ar_busy", arready, 0);
    for (int i = 0; i <= int'(len); i++) begin
      if (!ill) begin
        a = ref_addr(start, burst, size, len, i);
        check("req_valid", mem_req_valid, 1);
        check("req_addr", mem_req_addr, a);
        for (int s = 0; s < req_stall; s++) begin
          mem_req_ready = 1'b0;
          tick();
          check("req_hold_valid", mem_req_valid, 1);
          check("req_hold_addr", mem_req_addr, a);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("req_drop", mem_req_valid, 0);
        for (int s = 0; s < rsp_delay; s++) begin
          tick();
          check("wait_no_rvalid", rvalid, 0);
        end
        d             = {$urandom, $urandom};
        e             = (i == err_beat);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = d;
        mem_rsp_err   = e;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        mem_rsp_data  = '0;
      end else begin
        d = '0;
        e = 1'b1;
        check("ill_no_req", mem_req_valid, 0);
      end
      for (int s = 0; s <= r_stall; s++) begin
        check("rvalid", rvalid, 1);
        check("rdata", rdata, d);
        check("rresp", rresp, e ? 2'b10 : 2'b00);
        check("rid", rid, id);
        check("rlast", rlast, (i == int'(len)) ? 1 : 0);
        check("ar_blocked", arready, 0);
        if (s < r_stall) begin
          rready = 1'b0;
          tick();
        end
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
    check("done_rvalid", rvalid, 0);
    check("done_arready", arready, 1);
    check("done_no_req", mem_req_valid, 0);
  endtask

  initial begin
    logic [1:0]    b;
    logic [2:0]    sz;
    logic [7:0]    ln;
    logic [AW-1:0] st;
    logic [7:0]    wrap_lens [4];
    wrap_lens = '{8'd1, 8'd3, 8'd7, 8'd15};

    rst = 1'b1; arvalid = 1'b0; araddr = '0; arid = '0; arburst = '0; arsize = '0;
    arlen = '0; rready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_data = '0; mem_rsp_err = 1'b0;
    tick(); tick(); tick();
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rid", rid, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_req_addr", mem_req_addr, 0);
    rst = 1'b0;
    tick();
    check("post_rst_arready", arready, 1);

    // Directed bursts
    run_burst(4'd5, 32'h100, 2'b01, 3'd3, 8'd3, 0, 0, 0, -1);  // INCR
    run_burst(4'd2, 32'h118, 2'b10, 3'd3, 8'd3, 0, 1, 0, -1);  // WRAP
    run_burst(4'd7, 32'h40,  2'b00, 3'd3, 8'd2, 0, 0, 0, -1);  // FIXED
    run_burst(4'd1, 32'h103, 2'b01, 3'd2, 8'd1, 0, 0, 0, -1);  // unaligned INCR
    run_burst(4'd9, 32'h200, 2'b01, 3'd3, 8'd3, 3, 2, 5, -1);  // backpressure
    run_burst(4'd3, 32'h300, 2'b01, 3'd3, 8'd3, 0, 0, 0, 1);   // error on beat 2
`ifdef AXI_RD_LEGALITY_CHECK_EN
    run_burst(4'd4, 32'h100, 2'b10, 3'd3, 8'd2, 0, 0, 0, -1);  // illegal WRAP
`endif

    // Reset while waiting for the cache response: the burst must vanish.
    arvalid = 1'b1; arid = 4'd6; araddr = 32'h500; arburst = 2'b01; arsize = 3'd3; arlen = 8'd3;
    tick();
    arvalid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hDEAD_BEEF_0000_0001;
    tick();
    mem_rsp_valid = 1'b0;
    check("rstmid_rvalid", rvalid, 0);
    check("rstmid_arready", arready, 0);
    check("rstmid_req", mem_req_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    check("rstrel_arready", arready, 1);
    check("rstrel_rvalid", rvalid, 0);
    tick(); tick();
    check("rstrel_quiet_rvalid", rvalid, 0);
    check("rstrel_quiet_req", mem_req_valid, 0);

    // Randomized bursts
    for (int n = 0; n < 30; n++) begin
      b  = 2'($urandom_range(0, 3));
      sz = 3'($urandom_range(0, 3));
      st = $urandom;
      if (b == 2'b10) begin
        ln = wrap_lens[$urandom_range(0, 3)];
        st = st & ~((32'd1 << sz) - 32'd1);
      end else begin
        ln = 8'($urandom_range(0, 7));
      end
      run_burst(4'($urandom), st, b, sz, ln, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 8) - 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
